// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx: UART transmitter, 8N1 frames (start, 8 data bits LSB first, stop).
// Bit period matches uart_rx: CLK_PER_BIT = (CLK_FREQ + BAUD) / BAUD - 1.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit (8E1).
// Port list is identical in both builds.
module uart_tx #(
  parameter int  CLK_FREQ    = 50000000,
  parameter int  BAUD        = 500000,
  localparam int CLK_PER_BIT = (CLK_FREQ + BAUD) / BAUD - 1,
  localparam int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tx,
  input  logic       block,
  output logic       busy,
  input  logic [7:0] data,
  input  logic       new_data
);

  localparam logic [CTR_SIZE-1:0] CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              r_state;
  logic [CTR_SIZE-1:0] r_ctr;
  logic [2:0]          r_bit_ctr;
  logic [7:0]          r_shift;
  logic                r_tx;
  logic                r_busy;
  logic                r_block_q;
`ifdef UART_TX_PARITY_EN
  logic                r_parity;
`endif

  assign tx   = r_tx;
  assign busy = r_busy;

  // Frame sequencer with registered tx/busy. busy is loaded with the value
  // (next_state != IDLE) | block, i.e. what (state != IDLE) | block_q will be
  // after this edge, so it drops on the same edge the stop bit ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_ctr     <= '0;
      r_bit_ctr <= '0;
      r_block_q <= 1'b0;
    end else begin
      r_block_q <= block;
      case (r_state)
        S_IDLE: begin
          r_tx      <= 1'b1;
          r_ctr     <= '0;
          r_bit_ctr <= '0;
          r_busy    <= block;
          // Requests while block_q is high are dropped, not queued.
          if (!r_block_q && new_data) begin
            r_shift  <= data;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^data;
`endif
            r_state  <= S_START;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
          end
        end

        S_START: begin
          r_busy <= 1'b1;
          if (r_ctr == CTR_LAST) begin
            r_ctr   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_ctr <= r_ctr + 1'b1;
          end
        end

        S_DATA: begin
          r_busy <= 1'b1;
          if (r_ctr == CTR_LAST) begin
            r_ctr     <= '0;
            r_shift   <= r_shift >> 1;
            r_bit_ctr <= r_bit_ctr + 1'b1;
            if (r_bit_ctr == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              // Next bit is shift[1] since the shift happens on this edge.
              r_tx <= r_shift[1];
            end
          end else begin
            r_ctr <= r_ctr + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          r_busy <= 1'b1;
          if (r_ctr == CTR_LAST) begin
            r_ctr   <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_ctr <= r_ctr + 1'b1;
          end
        end
`endif

        S_STOP: begin
          r_tx <= 1'b1;
          if (r_ctr == CTR_LAST) begin
            r_ctr   <= '0;
            r_state <= S_IDLE;
            r_busy  <= block;
          end else begin
            r_ctr  <= r_ctr + 1'b1;
            r_busy <= 1'b1;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_tx      <= 1'b1;
          r_ctr     <= '0;
          r_bit_ctr <= '0;
          r_busy    <= block;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// tb_uart_tx: scoreboard bench for uart_tx at default parameters.
// Accepted bytes are queued when driven; a line monitor decodes each frame
// from tx and checks every bit period against the queued byte.
module tb_uart_tx;

  localparam int CPB = 100;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       block = 1'b0;
  logic       new_data = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx;
  logic       busy;

  uart_tx dut (
    .clk     (clk),
    .rst     (rst),
    .tx      (tx),
    .block   (block),
    .busy    (busy),
    .data    (data),
    .new_data(new_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int n_pushed = 0;
  int n_frames = 0;
  int n_abort = 0;
  bit b2b = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line monitor: finds the start edge, checks every cycle of every bit
  int          cyc_cnt = 0;
  bit          m_act = 1'b0;
  int          m_cyc = 0;
  int          m_err = 0;
  int          m_last_start = 0;
  bit          m_have_prev = 1'b0;
  logic        m_prev = 1'b1;
  logic [7:0]  m_expb = 8'h00;
  logic [7:0]  m_byte = 8'h00;
  logic [NB-1:0] m_bits = '0;

  always @(negedge clk) begin
    int k;
    cyc_cnt++;
    if (rst) begin
      if (m_act) n_abort++;
      m_act = 1'b0;
    end else if (!m_act) begin
      if (m_prev === 1'b1 && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          m_expb = 8'h00;
        end else begin
          m_expb = exp_q.pop_front();
        end
`ifdef UART_TX_PARITY_EN
        m_bits = {1'b1, ^m_expb, m_expb, 1'b0};
`else
        m_bits = {1'b1, m_expb, 1'b0};
`endif
        if (b2b) begin
          if (m_have_prev) chk("frame_gap", cyc_cnt - m_last_start, NB*CPB + 1);
          m_have_prev = 1'b1;
        end else begin
          m_have_prev = 1'b0;
        end
        m_last_start = cyc_cnt;
        m_act = 1'b1;
        m_cyc = 0;
        m_err = 0;
        m_byte = 8'h00;
      end
    end
    if (m_act && !rst) begin
      k = m_cyc / CPB;
      if (tx !== m_bits[k]) m_err++;
      if ((m_cyc % CPB) == CPB/2 && k >= 1 && k <= 8) m_byte[k-1] = tx;
      if ((m_cyc % CPB) == CPB-1) begin
        chk($sformatf("frame%0d_bit%0d_errcycles", n_frames, k), m_err, 0);
        m_err = 0;
      end
      m_cyc++;
      if (m_cyc == NB*CPB) begin
        chk($sformatf("frame%0d_rx_byte", n_frames), m_byte, m_expb);
        n_frames++;
        m_act = 1'b0;
      end
    end
    m_prev = tx;
  end

  // Called at a negedge; request spans one posedge. exp=1 means it must be accepted.
  task automatic send(input logic [7:0] d, input bit exp);
    data = d;
    new_data = 1'b1;
    if (exp) begin
      exp_q.push_back(d);
      n_pushed++;
    end
    @(negedge clk);
    new_data = 1'b0;
    data = 8'($urandom);
    if (exp) begin
      chk("start_tx_low", tx, 0);
      chk("start_busy", busy, 1);
    end
  endtask

  // Counts busy-high cycles (first one already elapsed); optional ignored request.
  task automatic wait_idle(output int len, input int inj_at, input logic [7:0] inj_d);
    len = 1;
    for (int i = 0; i < 3000; i++) begin
      if (inj_at != 0 && len == inj_at) begin
        data = inj_d;
        new_data = 1'b1;
      end else begin
        new_data = 1'b0;
      end
      @(negedge clk);
      if (!busy) break;
      len++;
    end
    new_data = 1'b0;
    if (busy) chk("busy_timeout", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int bad;
    logic [7:0] tbl[8];
    tbl = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h07, 8'hFE};

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("idle_500_bad_cycles", bad, 0);

    // Single frame
    send(8'hA5, 1);
    wait_idle(len, 0, 8'h00);
    chk("busy_len_A5", len, NB*CPB);

    // Request mid-frame is ignored
    send(8'h3C, 1);
    wait_idle(len, 250, 8'hFF);
    chk("busy_len_3C", len, NB*CPB);

    // Flow control
    block = 1'b1;
    @(negedge clk);
    chk("block_busy", busy, 1);
    send(8'h12, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("block_tx_idle", bad, 0);
    chk("block_busy_hold", busy, 1);
    block = 1'b0;
    repeat (2) @(negedge clk);
    chk("unblock_busy", busy, 0);
    send(8'h12, 1);
    wait_idle(len, 0, 8'h00);
    chk("busy_len_12", len, NB*CPB);

    // Reset during data bit 3
    send(8'hF0, 1);
    repeat (449) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h00, 1);
    wait_idle(len, 0, 8'h00);
    chk("busy_len_00", len, NB*CPB);

    // Back-to-back stream
    b2b = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send((i < 8) ? tbl[i] : 8'($urandom), 1);
      wait_idle(len, 0, 8'h00);
      chk($sformatf("b2b%0d_busy_len", i), len, NB*CPB);
    end
    b2b = 1'b0;
    repeat (5) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    chk("aborted_frames", n_abort, 1);
    chk("frames_accounted", n_frames + n_abort, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter: serializes 8-bit bytes onto a single TX line as 8N1 frames: start bit, 8 data bits LSB first, stop bit.
Mate of the uart_rx receiver. Uses the same CLK_FREQ/BAUD parameterization and rounding, so both ends agree on bit period.
Sits between a byte source (e.g. command/response logic) and the FPGA TX pin.
Simple valid-pulse handshake plus a flow-control input.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 500000, line rate in bits/s
CLK_PER_BIT, (CLK_FREQ + BAUD) / BAUD - 1, derived: clock cycles per bit (100 at defaults); not to be overridden
CTR_SIZE, $clog2(CLK_PER_BIT), derived: bit-period counter width

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
tx  output  1  serial line; idles high
block  input  1  flow control; when high, no new byte is accepted
busy  output  1  high while a frame is in progress or block is registered high
data  input  8  byte to send; sampled only in the accept cycle
new_data  input  1  single-cycle request to send data

Behaviour:
- Reset (rst high at clock edge): state=IDLE, tx=1, busy=0, counters cleared, block register cleared. Any frame in flight is abandoned; tx returns high on that edge. rst has priority over all other inputs.
- block is registered once (block_q); busy = (state != IDLE) | block_q; tx and busy are registered outputs.
- Accept condition: state==IDLE && !block_q && new_data.
  - In the accept cycle, data is latched into the shift register and ctr=0.
  - Next edge: state=START, tx=0, busy=1.
- new_data while busy, or while block_q is high, is ignored. It is not queued; no error flag.
- data changes after the accept cycle do not affect the frame.
- States:
  - IDLE: tx=1, ctr=0, bit_ctr=0; on accept go to START.
  - START: tx=0 for CLK_PER_BIT cycles (ctr counts 0..CLK_PER_BIT-1, wraps to 0), then go to DATA.
  - DATA: tx=shift[0] for CLK_PER_BIT cycles per bit. At each bit end, shift right and bit_ctr+1. After bit_ctr==7 completes, go to STOP (or PARITY, see Optional Feature). bit_ctr is 3 bits and wraps to 0 naturally.
  - STOP: tx=1 for CLK_PER_BIT cycles, then go to IDLE.
  - Illegal or unused encodings: go to IDLE with tx=1.
- Timing:
  - Frame length is 10*CLK_PER_BIT cycles from the tx falling edge to stop-bit end.
  - busy falls on the same edge STOP ends.
  - The earliest next accept is the first IDLE cycle, so back-to-back frames are spaced 10*CLK_PER_BIT+1 cycles apart.
- Asserting block mid-frame does not stop the current frame. It only prevents the next accept and holds busy high.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = even parity (XOR of the 8 latched data bits) for CLK_PER_BIT cycles. Frame becomes 11*CLK_PER_BIT cycles (8E1).
- Undefined: no PARITY state; 8N1 exactly as above. Port list is identical in both builds.

Test Plan:
1. Reset: assert rst for 2 cycles -> tx=1, busy=0. Hold new_data=0 for 500 cycles -> tx stays 1.
2. Send 0xA5 at defaults -> tx low on the edge after accept for 100 cycles. Then bits 1,0,1,0,0,1,0,1 at 100 cycles each, then stop 1 for 100 cycles. busy high for exactly 1000 cycles.
3. Accept 0x3C, then pulse new_data with data=0xFF at cycle 250 -> ignored. Line shows only the 0x3C frame; busy falls at cycle 1000.
4. block=1, pulse new_data with 0x12 -> tx stays 1 and busy=1. Release block, wait 2 cycles, pulse new_data with 0x12 -> full 0x12 frame transmitted.
5. Reset mid-frame during data bit 3 of 0xF0 -> tx=1 and busy=0 on the reset edge. Then send 0x00 -> clean frame: start plus eight 0 bits, stop 1.
6. Loopback tx into uart_rx (same parameters) and send 0x00..0xFF back-to-back -> uart_rx new_data pulses 256 times with data matching each byte. With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 and frame length 1100 cycles.
